// File: rtl/exu_mul_sched.sv
// exu_mul_sched: issue scheduler for the E1/E2/E3 multiply, carry-less
// multiply and field-reduce datapath. Arbitrates two pipe-slot requesters,
// decodes the granted op into datapath strobes, tracks tag/source of each
// in-flight op so the result comes back tagged in E3, and applies the
// freeze, flush and FFWIDTH-before-FFRED interlocks.
module exu_mul_sched #(
    parameter int TAGW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic [1:0]        req_valid,
    input  logic [7:0]        req_op,
    input  logic [2*TAGW-1:0] req_tag,
    output logic [1:0]        req_ready,
    output logic              mul_valid,
    output logic              mul_low,
    output logic              mul_rs1_sign,
    output logic              mul_rs2_sign,
    output logic              mul_clmul,
    output logic              mul_clmulh,
    output logic              mul_clmulr,
    output logic              mul_ffwidth,
    output logic              mul_ffred,
    output logic              res_valid,
    output logic              res_src,
    output logic [TAGW-1:0]   res_tag,
    output logic              op_err,
    output logic              busy
);

    localparam int NREQ = 2;

    localparam logic [3:0] OP_MUL     = 4'd0;
    localparam logic [3:0] OP_MULH    = 4'd1;
    localparam logic [3:0] OP_MULHSU  = 4'd2;
    localparam logic [3:0] OP_MULHU   = 4'd3;
    localparam logic [3:0] OP_CLMUL   = 4'd4;
    localparam logic [3:0] OP_CLMULH  = 4'd5;
    localparam logic [3:0] OP_CLMULR  = 4'd6;
    localparam logic [3:0] OP_FFWIDTH = 4'd7;
    localparam logic [3:0] OP_FFRED   = 4'd8;

    // One in-flight op as seen by a pipeline stage. has_result is 0 only
    // for FFWIDTH, which configures the datapath but writes nothing back.
    typedef struct packed {
        logic            valid;
        logic            src;
        logic [TAGW-1:0] tag;
        logic            has_result;
    } stage_t;

    // ------------------------------------------------------------------
    // Per-requester views of the packed request buses
    // ------------------------------------------------------------------
    logic [3:0]      op_w    [NREQ];
    logic [TAGW-1:0] tag_w   [NREQ];
    logic [NREQ-1:0] legal_w;

    // State
    stage_t s1_reg, s1_next;
    stage_t s2_reg, s2_next;
    stage_t s3_reg, s3_next;
    logic   cfg_valid_reg, cfg_valid_next;
    logic   last_reg, last_next;

    // Arbitration / issue
    logic            grant_en;
    logic            both_req;
    logic            sel;
    logic            gnt;
    logic [3:0]      sel_op;
    logic [TAGW-1:0] sel_tag;
    logic            sel_legal;
    logic            sel_is_ffred;
    logic            sel_is_ffwidth;
    logic            ffwidth_in_e1;
    logic            ffred_ok;
    logic            issue;
    stage_t          issue_stage;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign op_w[gi]    = req_op[4*gi +: 4];
            assign tag_w[gi]   = req_tag[TAGW*gi +: TAGW];
            assign legal_w[gi] = (op_w[gi] <= OP_FFRED);
            // Ready is the grant itself, so it is one-hot or zero.
            assign req_ready[gi] = gnt & (int'(sel) == gi);
        end
    endgenerate

    // Round-robin: with both valid the requester that did not win last
    // time goes; a lone requester always goes. Nothing is granted while
    // the pipe is frozen or being flushed.
    assign grant_en = ~freeze & ~flush;
    assign both_req = &req_valid;
    assign sel      = both_req ? ~last_reg : req_valid[1];
    assign gnt      = grant_en & (|req_valid);

    assign sel_op         = op_w[sel];
    assign sel_tag        = tag_w[sel];
    assign sel_legal      = legal_w[sel];
    assign sel_is_ffred   = (sel_op == OP_FFRED);
    assign sel_is_ffwidth = (sel_op == OP_FFWIDTH);

    // FFRED needs the field width configured: either an earlier FFWIDTH
    // already reached E2, or one sits in E1 right now and will configure
    // the datapath one cycle ahead of the FFRED. Flush blocks the grant,
    // so an E1 FFWIDTH seen here is never a flushed one.
    assign ffwidth_in_e1 = s1_reg.valid & ~s1_reg.has_result;
    assign ffred_ok      = cfg_valid_reg | ffwidth_in_e1;

    // A grant is consumed either way; it only reaches E1 if legal.
    assign issue  = gnt & sel_legal & (~sel_is_ffred | ffred_ok);
    assign op_err = gnt & ~issue;

    assign mul_valid = issue;

    // Decode the issued op into datapath strobes; all zero when idle.
    always_comb begin
        mul_low      = 1'b0;
        mul_rs1_sign = 1'b0;
        mul_rs2_sign = 1'b0;
        mul_clmul    = 1'b0;
        mul_clmulh   = 1'b0;
        mul_clmulr   = 1'b0;
        mul_ffwidth  = 1'b0;
        mul_ffred    = 1'b0;
        if (issue) begin
            case (sel_op)
                OP_MUL: begin
                    mul_low      = 1'b1;
                    mul_rs1_sign = 1'b1;
                    mul_rs2_sign = 1'b1;
                end
                OP_MULH: begin
                    mul_rs1_sign = 1'b1;
                    mul_rs2_sign = 1'b1;
                end
                OP_MULHSU: begin
                    mul_rs1_sign = 1'b1;
                end
                OP_MULHU: begin
                    // unsigned x unsigned, high half: no strobe set
                end
                OP_CLMUL:   mul_clmul   = 1'b1;
                OP_CLMULH:  mul_clmulh  = 1'b1;
                OP_CLMULR:  mul_clmulr  = 1'b1;
                OP_FFWIDTH: mul_ffwidth = 1'b1;
                OP_FFRED:   mul_ffred   = 1'b1;
                default: begin
                    // illegal codes never issue
                end
            endcase
        end
    end

    // Stage advance: everything moves one step on an unfrozen edge; flush
    // kills whatever would land in S1/S2 (even when frozen) while the op
    // leaving E2 still reaches S3 and is delivered.
    always_comb begin
        issue_stage            = '0;
        issue_stage.valid      = issue;
        issue_stage.src        = sel;
        issue_stage.tag        = sel_tag;
        issue_stage.has_result = ~sel_is_ffwidth;

        s1_next = s1_reg;
        s2_next = s2_reg;
        s3_next = s3_reg;
        if (!freeze) begin
            s1_next = issue_stage;
            s2_next = s1_reg;
            s3_next = s2_reg;
        end
        if (flush) begin
            s1_next.valid = 1'b0;
            s2_next.valid = 1'b0;
        end
    end

    // Field config becomes sticky once an FFWIDTH leaves E1 for E2.
    always_comb begin
        cfg_valid_next = cfg_valid_reg;
        if (ffwidth_in_e1 && !freeze && !flush) begin
            cfg_valid_next = 1'b1;
        end
    end

    // Remember who won the most recent grant for round-robin fairness.
    always_comb begin
        last_next = last_reg;
        if (gnt) begin
            last_next = sel;
        end
    end

    // State registers; reset drops every in-flight op and hands the first
    // contested grant to requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg        <= '0;
            s2_reg        <= '0;
            s3_reg        <= '0;
            cfg_valid_reg <= 1'b0;
            last_reg      <= 1'b1;
        end else begin
            s1_reg        <= s1_next;
            s2_reg        <= s2_next;
            s3_reg        <= s3_next;
            cfg_valid_reg <= cfg_valid_next;
            last_reg      <= last_next;
        end
    end

    // A frozen E3 holds its result back until the datapath runs again.
    assign res_valid = s3_reg.valid & s3_reg.has_result & ~freeze;
    assign res_src   = res_valid ? s3_reg.src : 1'b0;
    assign res_tag   = res_valid ? s3_reg.tag : '0;
    assign busy      = s1_reg.valid | s2_reg.valid | s3_reg.valid;

endmodule

// File: tb/tb_exu_mul_sched.sv
// Testbench for exu_mul_sched: directed scenarios with literal expectations
// followed by a long randomized run, all checked every cycle against a
// list-of-in-flight-ops model.
module tb_exu_mul_sched;

    localparam int TAGW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              freeze = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [7:0]        req_op = 8'h00;
    logic [2*TAGW-1:0] req_tag = '0;
    logic [1:0]        req_ready;
    logic              mul_valid, mul_low, mul_rs1_sign, mul_rs2_sign;
    logic              mul_clmul, mul_clmulh, mul_clmulr, mul_ffwidth, mul_ffred;
    logic              res_valid, res_src;
    logic [TAGW-1:0]   res_tag;
    logic              op_err, busy;

    exu_mul_sched #(.TAGW(TAGW)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_tag      (req_tag),
        .req_ready    (req_ready),
        .mul_valid    (mul_valid),
        .mul_low      (mul_low),
        .mul_rs1_sign (mul_rs1_sign),
        .mul_rs2_sign (mul_rs2_sign),
        .mul_clmul    (mul_clmul),
        .mul_clmulh   (mul_clmulh),
        .mul_clmulr   (mul_clmulr),
        .mul_ffwidth  (mul_ffwidth),
        .mul_ffred    (mul_ffred),
        .res_valid    (res_valid),
        .res_src      (res_src),
        .res_tag      (res_tag),
        .op_err       (op_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: each in-flight op with the number of pipeline steps it has made
    // (1 = E1, 2 = E2, 3 = E3).
    typedef struct {
        bit            src;
        bit [TAGW-1:0] tag;
        bit            has_res;
        bit            is_ffw;
        int            age;
    } flight_t;

    flight_t fl[$];
    bit      m_cfg;
    bit      m_last;

    // Expected values for the current cycle
    bit            e_gnt, e_sel, e_issue, e_err, e_busy;
    bit [3:0]      e_op;
    bit [TAGW-1:0] e_tag;
    bit [1:0]      e_ready;
    bit [7:0]      e_strb;
    bit            e_res_valid, e_res_src;
    bit [TAGW-1:0] e_res_tag;

    // Sampled DUT outputs for the current cycle
    logic [1:0]      s_ready;
    logic            s_mul_valid, s_err, s_res_valid, s_res_src, s_busy;
    logic [7:0]      s_strb;
    logic [TAGW-1:0] s_res_tag;

    // Per-cycle history for directed scenarios
    logic [1:0]      h_ready [16];
    logic            h_mv    [16];
    logic [7:0]      h_strb  [16];
    logic            h_err   [16];
    logic            h_rv    [16];
    logic            h_src   [16];
    logic [TAGW-1:0] h_tag   [16];
    logic            h_busy  [16];

    // Strobe vector order: {low, rs1_sign, rs2_sign, clmul, clmulh, clmulr, ffwidth, ffred}
    function automatic bit [7:0] op_strobes(input bit [3:0] op);
        case (op)
            4'd0:    return 8'b1110_0000;
            4'd1:    return 8'b0110_0000;
            4'd2:    return 8'b0100_0000;
            4'd3:    return 8'b0000_0000;
            4'd4:    return 8'b0001_0000;
            4'd5:    return 8'b0000_1000;
            4'd6:    return 8'b0000_0100;
            4'd7:    return 8'b0000_0010;
            4'd8:    return 8'b0000_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        m_cfg  = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic model_expect();
        bit ffw_e1;
        ffw_e1 = 1'b0;
        foreach (fl[i]) begin
            if (fl[i].age == 1 && fl[i].is_ffw) ffw_e1 = 1'b1;
        end
        e_gnt   = !freeze && !flush && (req_valid != 2'b00);
        e_sel   = (req_valid == 2'b11) ? !m_last : req_valid[1];
        e_op    = e_sel ? req_op[7:4] : req_op[3:0];
        e_tag   = e_sel ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
        e_issue = e_gnt && (e_op <= 4'd8) && !(e_op == 4'd8 && !(m_cfg || ffw_e1));
        e_err   = e_gnt && !e_issue;
        e_ready = e_gnt ? (e_sel ? 2'b10 : 2'b01) : 2'b00;
        e_strb  = e_issue ? op_strobes(e_op) : 8'h00;
        e_res_valid = 1'b0;
        e_res_src   = 1'b0;
        e_res_tag   = '0;
        foreach (fl[i]) begin
            if (fl[i].age == 3 && fl[i].has_res && !freeze) begin
                e_res_valid = 1'b1;
                e_res_src   = fl[i].src;
                e_res_tag   = fl[i].tag;
            end
        end
        e_busy = (fl.size() != 0);
    endtask

    task automatic model_advance();
        flight_t nxt[$];
        flight_t n;
        if (!freeze && !flush) begin
            foreach (fl[i]) begin
                if (fl[i].age == 1 && fl[i].is_ffw) m_cfg = 1'b1;
            end
        end
        foreach (fl[i]) begin
            flight_t e;
            e = fl[i];
            if (!freeze) e.age++;
            if (e.age <= 3 && !(flush && e.age <= 2)) nxt.push_back(e);
        end
        if (e_issue) begin
            n.src     = e_sel;
            n.tag     = e_tag;
            n.has_res = (e_op != 4'd7);
            n.is_ffw  = (e_op == 4'd7);
            n.age     = 1;
            nxt.push_back(n);
        end
        fl = nxt;
        if (e_gnt) m_last = e_sel;
    endtask

    // One clock cycle: inputs are already applied; compare at the negedge,
    // then advance the model on the posedge.
    task automatic step();
        if (rst) model_reset();
        model_expect();
        @(negedge clk);
        s_ready     = req_ready;
        s_mul_valid = mul_valid;
        s_strb      = {mul_low, mul_rs1_sign, mul_rs2_sign, mul_clmul,
                       mul_clmulh, mul_clmulr, mul_ffwidth, mul_ffred};
        s_err       = op_err;
        s_res_valid = res_valid;
        s_res_src   = res_src;
        s_res_tag   = res_tag;
        s_busy      = busy;
        chk("req_ready", 32'(s_ready), 32'(e_ready));
        chk("mul_valid", 32'(s_mul_valid), 32'(e_issue));
        chk("strobes", 32'(s_strb), 32'(e_strb));
        chk("op_err", 32'(s_err), 32'(e_err));
        chk("res_valid", 32'(s_res_valid), 32'(e_res_valid));
        chk("res_src", 32'(s_res_src), 32'(e_res_src));
        chk("res_tag", 32'(s_res_tag), 32'(e_res_tag));
        chk("busy", 32'(s_busy), 32'(e_busy));
        @(posedge clk);
        if (rst) model_reset();
        else model_advance();
        #1;
        cyc++;
    endtask

    task automatic rec(input int c);
        h_ready[c] = s_ready;
        h_mv[c]    = s_mul_valid;
        h_strb[c]  = s_strb;
        h_err[c]   = s_err;
        h_rv[c]    = s_res_valid;
        h_src[c]   = s_res_src;
        h_tag[c]   = s_res_tag;
        h_busy[c]  = s_busy;
    endtask

    task automatic idle();
        req_valid = 2'b00;
        freeze    = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;

        // A: single MULHU from requester 0
        do_reset();
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_res_valid", 32'(s_res_valid), 32'd0);
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c == 0) begin
                req_valid = 2'b01;
                req_op    = {4'd0, 4'd3};
                req_tag   = {5'd0, 5'h0A};
            end
            step();
            rec(c);
        end
        chk("A_mul_valid", 32'(h_mv[0]), 32'd1);
        chk("A_strobes", 32'(h_strb[0]), 32'h00);
        chk("A_ready", 32'(h_ready[0]), 32'd1);
        chk("A_res_valid_c2", 32'(h_rv[2]), 32'd0);
        chk("A_res_valid_c3", 32'(h_rv[3]), 32'd1);
        chk("A_res_src", 32'(h_src[3]), 32'd0);
        chk("A_res_tag", 32'(h_tag[3]), 32'h0A);

        // B: both requesters contend for 4 cycles
        do_reset();
        for (int c = 0; c < 7; c++) begin
            idle();
            req_valid = (c < 4) ? 2'b11 : 2'b00;
            req_op    = {4'd0, 4'd0};
            req_tag   = {5'd2, 5'd1};
            step();
            rec(c);
        end
        for (int c = 0; c < 4; c++) begin
            chk("B_ready", 32'(h_ready[c]), (c % 2 == 0) ? 32'd1 : 32'd2);
        end
        for (int c = 3; c < 7; c++) begin
            chk("B_res_valid", 32'(h_rv[c]), 32'd1);
            chk("B_res_tag", 32'(h_tag[c]), ((c - 3) % 2 == 0) ? 32'd1 : 32'd2);
            chk("B_res_src", 32'(h_src[c]), ((c - 3) % 2 == 0) ? 32'd0 : 32'd1);
        end

        // C: freeze in cycles 1-2 stretches latency to 5
        do_reset();
        for (int c = 0; c < 8; c++) begin
            idle();
            req_valid = (c <= 2) ? 2'b01 : 2'b00;
            req_op    = {4'd0, 4'd1};
            req_tag   = {5'd0, 5'h11};
            freeze    = (c == 1 || c == 2);
            step();
            rec(c);
        end
        chk("C_ready_c0", 32'(h_ready[0]), 32'd1);
        chk("C_ready_c1", 32'(h_ready[1]), 32'd0);
        chk("C_ready_c2", 32'(h_ready[2]), 32'd0);
        for (int c = 1; c < 8; c++) begin
            chk("C_res_valid", 32'(h_rv[c]), (c == 5) ? 32'd1 : 32'd0);
        end
        chk("C_res_tag", 32'(h_tag[5]), 32'h11);

        // D: flush in cycle 2 with ops issued in 0 and 1
        do_reset();
        for (int c = 0; c < 6; c++) begin
            idle();
            req_valid = (c <= 2) ? 2'b01 : 2'b00;
            req_op    = {4'd0, 4'd4};
            req_tag   = {5'd0, 5'(3 + c)};
            flush     = (c == 2);
            step();
            rec(c);
        end
        chk("D_ready_c2", 32'(h_ready[2]), 32'd0);
        chk("D_res_valid_c3", 32'(h_rv[3]), 32'd1);
        chk("D_res_tag_c3", 32'(h_tag[3]), 32'd3);
        chk("D_busy_c4", 32'(h_busy[4]), 32'd0);
        chk("D_res_valid_c4", 32'(h_rv[4]), 32'd0);
        chk("D_res_valid_c5", 32'(h_rv[5]), 32'd0);

        // E: FFRED without configuration is consumed with an error
        do_reset();
        idle();
        req_valid = 2'b01;
        req_op    = {4'd0, 4'd8};
        step();
        chk("E_ready", 32'(s_ready), 32'd1);
        chk("E_op_err", 32'(s_err), 32'd1);
        chk("E_mul_valid", 32'(s_mul_valid), 32'd0);
        idle();
        step();
        chk("E_busy", 32'(s_busy), 32'd0);

        // F: FFWIDTH then FFRED back to back
        do_reset();
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c == 0) begin
                req_valid = 2'b01;
                req_op    = {4'd0, 4'd7};
                req_tag   = {5'd0, 5'd7};
            end else if (c == 1) begin
                req_valid = 2'b01;
                req_op    = {4'd0, 4'd8};
                req_tag   = {5'd0, 5'd9};
            end
            step();
            rec(c);
        end
        chk("F_strb_c0", 32'(h_strb[0]), 32'h02);
        chk("F_mul_valid_c1", 32'(h_mv[1]), 32'd1);
        chk("F_strb_c1", 32'(h_strb[1]), 32'h01);
        chk("F_op_err_c1", 32'(h_err[1]), 32'd0);
        for (int c = 2; c < 6; c++) begin
            chk("F_res_valid", 32'(h_rv[c]), (c == 4) ? 32'd1 : 32'd0);
        end
        chk("F_res_tag", 32'(h_tag[4]), 32'd9);

        // G: illegal op code 0xC
        do_reset();
        idle();
        req_valid = 2'b01;
        req_op    = {4'd0, 4'hC};
        step();
        chk("G_ready", 32'(s_ready), 32'd1);
        chk("G_op_err", 32'(s_err), 32'd1);
        chk("G_mul_valid", 32'(s_mul_valid), 32'd0);
        idle();
        step();
        chk("G_busy", 32'(s_busy), 32'd0);

        // H: reset while ops are in flight drops them silently
        do_reset();
        for (int c = 0; c < 2; c++) begin
            idle();
            req_valid = 2'b01;
            req_op    = {4'd0, 4'd0};
            req_tag   = {5'd0, 5'(20 + c)};
            step();
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle();
            step();
            rec(c);
        end
        for (int c = 0; c < 4; c++) begin
            chk("H_res_valid", 32'(h_rv[c]), 32'd0);
            chk("H_busy", 32'(h_busy[c]), 32'd0);
        end

        // Randomized traffic checked against the model every cycle
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] op0, op1;
            req_valid = 2'($urandom_range(0, 3));
            op0 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            op1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            req_op  = {op1, op0};
            req_tag = 10'($urandom);
            freeze  = ($urandom_range(0, 9) == 0);
            flush   = ($urandom_range(0, 14) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
